// File: rtl/arduino_rx_bank.sv
// Multi-lane serial receiver: synchronises external clock/data pins, shifts words MSB-first
// and hands each lane's word out on valid/ready. Optional even-parity framing: ARDUINO_RX_PARITY_EN.
module arduino_rx_bank #(
   parameter int CHANNELS    = 2,
   parameter int WORD_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1023
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       enable,
   input  logic                       clear_err,
   input  logic [CHANNELS-1:0]        ard_clk,
   input  logic [CHANNELS-1:0]        ard_data,
   output logic [CHANNELS*WORD_W-1:0] word_out,
   output logic [CHANNELS-1:0]        word_valid,
   input  logic [CHANNELS-1:0]        word_ready,
   output logic [CHANNELS-1:0]        overrun,
   output logic [CHANNELS-1:0]        parity_err
);

`ifdef ARDUINO_RX_PARITY_EN
   localparam int FRAME = WORD_W + 1;
`else
   localparam int FRAME = WORD_W;
`endif
   localparam int SHIFT_W = FRAME - 1;
   localparam int CNT_W   = $clog2(FRAME + 1);
   localparam int TO_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      logic [SYNC_STAGES-1:0] r_clk_sync;
      logic [SYNC_STAGES-1:0] r_dat_sync;
      logic                   r_clk_prev;
      logic [SHIFT_W-1:0]     r_shift;
      logic [CNT_W-1:0]       r_cnt;
      logic [TO_W-1:0]        r_tcnt;
      logic [WORD_W-1:0]      r_word;
      logic                   r_valid;
      logic                   r_ovr;
      logic                   r_perr;

      logic                   w_clk_s;
      logic                   w_dat_s;
      logic                   w_edge;
      logic                   w_last;
      logic [FRAME-1:0]       w_cat;
      logic [WORD_W-1:0]      w_word;
      logic                   w_par_ok;
      logic                   w_done;
      logic                   w_load;
      logic                   w_ovr_set;
      logic                   w_perr_set;

      assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
      assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
      // Edges are gated by enable but r_clk_prev always tracks, so enabling never fakes an edge.
      assign w_edge  = enable & w_clk_s & ~r_clk_prev;
      assign w_last  = w_edge && (r_cnt == LAST_BIT);
      assign w_cat   = {r_shift, w_dat_s};

`ifdef ARDUINO_RX_PARITY_EN
      assign w_word   = w_cat[FRAME-1:1];
      assign w_par_ok = ~(^w_cat);
`else
      assign w_word   = w_cat;
      assign w_par_ok = 1'b1;
`endif

      assign w_done     = w_last & w_par_ok;
      assign w_load     = w_done & (~r_valid | word_ready[i]);
      assign w_ovr_set  = w_done & r_valid & ~word_ready[i];
      assign w_perr_set = w_last & ~w_par_ok;

      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            r_clk_sync <= '0;
            r_dat_sync <= '0;
            r_clk_prev <= 1'b0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_tcnt     <= '0;
            r_word     <= '0;
            r_valid    <= 1'b0;
            r_ovr      <= 1'b0;
            r_perr     <= 1'b0;
         end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ard_clk[i]};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ard_data[i]};
            r_clk_prev <= w_clk_s;

            if (!enable) begin
               r_cnt   <= '0;
               r_tcnt  <= '0;
               r_shift <= '0;
            end else if (w_edge) begin
               r_tcnt  <= '0;
               r_shift <= w_cat[SHIFT_W-1:0];
               r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            end else if (r_cnt != '0) begin
               // A stalled partial frame is discarded once the idle count reaches TIMEOUT.
               if (r_tcnt == TO_LAST) begin
                  r_cnt   <= '0;
                  r_shift <= '0;
                  r_tcnt  <= '0;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end else begin
               r_tcnt <= '0;
            end

            if (w_load) begin
               r_word  <= w_word;
               r_valid <= 1'b1;
            end else if (r_valid && word_ready[i]) begin
               r_valid <= 1'b0;
            end

            r_ovr  <= (r_ovr & ~clear_err) | w_ovr_set;
            r_perr <= (r_perr & ~clear_err) | w_perr_set;
         end
      end

      assign word_out[i*WORD_W +: WORD_W] = r_word;
      assign word_valid[i]                = r_valid;
      assign overrun[i]                   = r_ovr;
      assign parity_err[i]                = r_perr;
   end

endmodule

// File: tb/tb_arduino_rx_bank.sv
// Directed bench for arduino_rx_bank: vector table of single words plus hand-written
// sequences for reset, latency, overrun, simultaneous accept, timeout, enable and parity.
module tb_arduino_rx_bank;
   localparam int CH = 2;
   localparam int WW = 8;
   localparam int TO = 16;
`ifdef ARDUINO_RX_PARITY_EN
   localparam int FRAME = WW + 1;
`else
   localparam int FRAME = WW;
`endif

   logic             clock = 1'b0;
   logic             resetn = 1'b0;
   logic             enable = 1'b0;
   logic             clear_err = 1'b0;
   logic [CH-1:0]    ard_clk = '0;
   logic [CH-1:0]    ard_data = '0;
   logic [CH-1:0]    word_ready = '0;
   logic [CH*WW-1:0] word_out;
   logic [CH-1:0]    word_valid;
   logic [CH-1:0]    overrun;
   logic [CH-1:0]    parity_err;

   int n_cmp = 0;
   int n_bad = 0;
   int acc_cnt [CH] = '{0, 0};
   int vcyc    [CH] = '{0, 0};
   logic [WW-1:0] acc_word [CH] = '{8'h00, 8'h00};

   typedef struct {
      int          lane;
      logic [WW-1:0] data;
      logic [WW-1:0] exp_word;
   } vec_t;
   vec_t vecs [5];

   arduino_rx_bank #(
      .CHANNELS(CH), .WORD_W(WW), .SYNC_STAGES(2), .TIMEOUT(TO)
   ) dut (
      .clock(clock), .resetn(resetn), .enable(enable), .clear_err(clear_err),
      .ard_clk(ard_clk), .ard_data(ard_data), .word_out(word_out),
      .word_valid(word_valid), .word_ready(word_ready),
      .overrun(overrun), .parity_err(parity_err)
   );

   always #5 clock = ~clock;

   // Consumer-side record: accepted words and cycles spent valid, per lane.
   always @(negedge clock) begin
      if (resetn) begin
         for (int l = 0; l < CH; l++) begin
            if (word_valid[l]) vcyc[l] <= vcyc[l] + 1;
            if (word_valid[l] && word_ready[l]) begin
               acc_cnt[l]  <= acc_cnt[l] + 1;
               acc_word[l] <= word_out[l*WW +: WW];
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [FRAME-1:0] frame_bits(input logic [WW-1:0] w);
`ifdef ARDUINO_RX_PARITY_EN
      return {w, ^w};
`else
      return w;
`endif
   endfunction

   task automatic send_bit(input int ln, input logic b);
      ard_data[ln] = b;
      tick(2);
      ard_clk[ln] = 1'b1;
      tick(3);
      ard_clk[ln] = 1'b0;
      tick(3);
   endtask

   task automatic send_frame(input int ln, input logic [FRAME-1:0] bits);
      for (int i = FRAME - 1; i >= 0; i--) send_bit(ln, bits[i]);
   endtask

   task automatic send_head(input int ln, input logic [FRAME-1:0] bits);
      for (int i = FRAME - 1; i >= 1; i--) send_bit(ln, bits[i]);
   endtask

   task automatic send_word(input int ln, input logic [WW-1:0] w);
      send_frame(ln, frame_bits(w));
   endtask

   initial begin
      int b, b1, v0, v1, ln;
      logic [FRAME-1:0] bits;

      vecs[0] = '{0, 8'hA5, 8'hA5};
      vecs[1] = '{1, 8'h3C, 8'h3C};
      vecs[2] = '{0, 8'h00, 8'h00};
      vecs[3] = '{1, 8'hFF, 8'hFF};
      vecs[4] = '{1, 8'h81, 8'h81};

      tick(2);
      check("rst_valid", word_valid, 0);
      check("rst_word", word_out, 0);
      check("rst_overrun", overrun, 0);
      check("rst_parity", parity_err, 0);
      resetn = 1'b1;
      enable = 1'b1;
      word_ready = 2'b11;
      tick(2);

      for (int v = 0; v < 5; v++) begin
         ln = vecs[v].lane;
         b = acc_cnt[ln];
         send_word(ln, vecs[v].data);
         tick(4);
         check("tbl_count", acc_cnt[ln] - b, 1);
         check("tbl_word", acc_word[ln], vecs[v].exp_word);
         check("tbl_overrun", overrun, 0);
      end

      // Reset in the middle of a frame, then a clean word with latency check.
      b = acc_cnt[0];
      send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b1);
      send_bit(0, 1'b1); send_bit(0, 1'b0);
      resetn = 1'b0;
      tick(3);
      resetn = 1'b1;
      check("midrst_valid", word_valid, 0);
      check("midrst_word", word_out, 0);
      bits = frame_bits(8'hA5);
      send_head(0, bits);
      ard_data[0] = bits[0];
      tick(2);
      ard_clk[0] = 1'b1;
      tick(2);
      check("lat_k1_valid", word_valid[0], 1'b0);
      tick(1);
      check("lat_k2_valid", word_valid[0], 1'b1);
      check("lat_k2_word", word_out[7:0], 8'hA5);
      ard_clk[0] = 1'b0;
      tick(3);
      check("midrst_count", acc_cnt[0] - b, 1);

      // Enable low: edges ignored; after enabling, one clean word.
      enable = 1'b0;
      b = acc_cnt[0];
      send_word(0, 8'hF0);
      tick(4);
      check("dis_count", acc_cnt[0] - b, 0);
      enable = 1'b1;
      tick(2);
      send_word(0, 8'h42);
      tick(4);
      check("en_count", acc_cnt[0] - b, 1);
      check("en_word", acc_word[0], 8'h42);

      // Two lanes concurrently with interleaved edges.
      b = acc_cnt[0]; b1 = acc_cnt[1]; v0 = vcyc[0]; v1 = vcyc[1];
      fork
         send_word(0, 8'h3C);
         begin
            tick(4);
            send_word(1, 8'hC3);
         end
      join
      tick(4);
      check("dual_cnt0", acc_cnt[0] - b, 1);
      check("dual_cnt1", acc_cnt[1] - b1, 1);
      check("dual_word0", acc_word[0], 8'h3C);
      check("dual_word1", acc_word[1], 8'hC3);
      check("dual_vcyc0", vcyc[0] - v0, 1);
      check("dual_vcyc1", vcyc[1] - v1, 1);
      check("dual_overrun", overrun, 0);

      // Overrun: second word dropped while the first is held.
      word_ready[0] = 1'b0;
      send_word(0, 8'h11);
      send_word(0, 8'h22);
      tick(4);
      check("ovr_valid", word_valid[0], 1'b1);
      check("ovr_word", word_out[7:0], 8'h11);
      check("ovr_flag", overrun, 2'b01);
      word_ready[0] = 1'b1;
      tick(1);
      check("ovr_accept_valid", word_valid[0], 1'b0);
      check("ovr_accept_word", acc_word[0], 8'h11);
      check("ovr_sticky", overrun, 2'b01);
      clear_err = 1'b1;
      tick(1);
      clear_err = 1'b0;
      check("ovr_cleared", overrun, 0);

      // Acceptance of 0x55 coincides with completion of 0x66.
      word_ready[0] = 1'b0;
      b = acc_cnt[0];
      send_word(0, 8'h55);
      tick(2);
      check("sim_first_valid", word_valid[0], 1'b1);
      bits = frame_bits(8'h66);
      send_head(0, bits);
      ard_data[0] = bits[0];
      tick(2);
      ard_clk[0] = 1'b1;
      tick(2);
      word_ready[0] = 1'b1;
      tick(1);
      check("sim_valid", word_valid[0], 1'b1);
      check("sim_word", word_out[7:0], 8'h66);
      check("sim_overrun", overrun, 0);
      ard_clk[0] = 1'b0;
      tick(3);
      check("sim_count", acc_cnt[0] - b, 2);
      check("sim_last_word", acc_word[0], 8'h66);
      check("sim_drained", word_valid[0], 1'b0);

      // Partial frame abandoned by timeout.
      b = acc_cnt[0];
      send_bit(0, 1'b1); send_bit(0, 1'b1); send_bit(0, 1'b1);
      tick(20);
      send_word(0, 8'h81);
      tick(4);
      check("to_count", acc_cnt[0] - b, 1);
      check("to_word", acc_word[0], 8'h81);

`ifdef ARDUINO_RX_PARITY_EN
      b = acc_cnt[0];
      send_frame(0, {8'h0F, 1'b0});
      tick(4);
      check("par_ok_count", acc_cnt[0] - b, 1);
      check("par_ok_word", acc_word[0], 8'h0F);
      check("par_ok_flag", parity_err, 0);
      b = acc_cnt[0]; v0 = vcyc[0];
      send_frame(0, {8'h0F, 1'b1});
      tick(4);
      check("par_bad_count", acc_cnt[0] - b, 0);
      check("par_bad_vcyc", vcyc[0] - v0, 0);
      check("par_bad_flag", parity_err, 2'b01);
      check("par_bad_overrun", overrun, 0);
      clear_err = 1'b1;
      tick(1);
      clear_err = 1'b0;
      check("par_cleared", parity_err, 0);
`else
      check("parity_const", parity_err, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
